// File: rtl/aemb_wb_arbiter.sv
// aemb_wb_arbiter
// Two-master (instruction / data) to one-slave Wishbone-classic arbiter for
// the AEMB core. Grants are round-robin, registered, and held until the slave
// acks, the master withdraws its strobe, or the per-transaction watchdog
// expires and returns an error pulse to the granted master.

module aemb_wb_arbiter #(
  parameter int ISIZ = 16,  // instruction address width
  parameter int DSIZ = 16,  // data address width
  parameter int TOUT = 15   // cycles without ack before timeout, 1..255
) (
  input  logic                                 sys_clk_i,
  input  logic                                 sys_rst_i,
  // instruction master
  input  logic [ISIZ-1:0]                      iwb_adr_i,
  input  logic                                 iwb_stb_i,
  output logic [31:0]                          iwb_dat_o,
  output logic                                 iwb_ack_o,
  output logic                                 iwb_err_o,
  // data master
  input  logic [DSIZ-1:0]                      dwb_adr_i,
  input  logic [31:0]                          dwb_dat_i,
  input  logic                                 dwb_we_i,
  input  logic                                 dwb_stb_i,
  output logic [31:0]                          dwb_dat_o,
  output logic                                 dwb_ack_o,
  output logic                                 dwb_err_o,
  // unified memory port
  output logic [((ISIZ > DSIZ) ? ISIZ : DSIZ)-1:0] mwb_adr_o,
  output logic [31:0]                          mwb_dat_o,
  output logic                                 mwb_we_o,
  output logic                                 mwb_stb_o,
  input  logic [31:0]                          mwb_dat_i,
  input  logic                                 mwb_ack_i
);

  localparam int ASIZ = (ISIZ > DSIZ) ? ISIZ : DSIZ;
  localparam logic [7:0] CNT_LAST = 8'(TOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IGNT    = 2'd1,
    DGNT    = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t     r_fsm;
  state_t     nxt_fsm;
  logic       r_last;   // last master granted: 0 = instruction, 1 = data
  logic [7:0] r_cnt;    // granted cycles seen without ack

  logic gnt_stb;        // granted master is still strobing
  logic timeout;        // watchdog expires this cycle (an ack would win)

  assign gnt_stb = ((r_fsm == IGNT) && iwb_stb_i) || ((r_fsm == DGNT) && dwb_stb_i);
  assign timeout = gnt_stb && !mwb_ack_i && (r_cnt == CNT_LAST);

  // Read data is broadcast to both masters; the acks say who it belongs to.
  assign iwb_dat_o = mwb_dat_i;
  assign dwb_dat_o = mwb_dat_i;

  // State register: grant state, round-robin pointer and watchdog counter.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_fsm  <= IDLE;
      r_last <= 1'b1;
      r_cnt  <= 8'd0;
    end else begin
      r_fsm <= nxt_fsm;
      if ((r_fsm == IDLE) && (nxt_fsm != IDLE))
        r_last <= (nxt_fsm == DGNT);
      if ((r_fsm == IDLE) || (nxt_fsm == IDLE))
        r_cnt <= 8'd0;
      else
        r_cnt <= r_cnt + 8'd1;
    end
  end

  // Next-state logic: round-robin arbitration in IDLE, release on ack,
  // abort or timeout while granted.
  always_comb begin
    // NOTE: default assignment first so no path leaves nxt_fsm unassigned,
    // which would otherwise infer a latch.
    nxt_fsm = r_fsm;
    case (r_fsm)
      IDLE: begin
        if (iwb_stb_i && dwb_stb_i)
          nxt_fsm = r_last ? IGNT : DGNT;
        else if (iwb_stb_i)
          nxt_fsm = IGNT;
        else if (dwb_stb_i)
          nxt_fsm = DGNT;
        else
          nxt_fsm = IDLE;
      end
      IGNT, DGNT: begin
        if (!gnt_stb || mwb_ack_i || timeout)
          nxt_fsm = IDLE;
      end
      default: nxt_fsm = IDLE;
    endcase
  end

  // Output logic: steer the granted master onto the memory port and route
  // ack / err back to it only.
  always_comb begin
    mwb_stb_o = 1'b0;
    mwb_we_o  = 1'b0;
    mwb_adr_o = '0;
    mwb_dat_o = dwb_dat_i;
    iwb_ack_o = 1'b0;
    iwb_err_o = 1'b0;
    dwb_ack_o = 1'b0;
    dwb_err_o = 1'b0;
    case (r_fsm)
      IGNT: begin
        mwb_stb_o = iwb_stb_i;
        mwb_adr_o = ASIZ'(iwb_adr_i);
        iwb_ack_o = mwb_ack_i && iwb_stb_i;
        iwb_err_o = timeout;
      end
      DGNT: begin
        mwb_stb_o = dwb_stb_i;
        mwb_we_o  = dwb_we_i;
        mwb_adr_o = ASIZ'(dwb_adr_i);
        dwb_ack_o = mwb_ack_i && dwb_stb_i;
        dwb_err_o = timeout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aemb_wb_arbiter.sv
// Self-checking bench for aemb_wb_arbiter (TOUT = 4).
// Cycle vectors hold inputs plus expected outputs; each vector's expectation
// is queued when it is driven and popped when the outputs are sampled on the
// falling edge.

module tb_aemb_wb_arbiter;

  localparam int TOUT = 4;
  localparam logic [15:0] IADR = 16'h1234;
  localparam logic [15:0] DADR = 16'h8888;
  localparam logic [31:0] DDAT = 32'h7a55ed00;

  logic        clk = 1'b0;
  logic        sys_rst_i;
  logic [15:0] iwb_adr_i;
  logic        iwb_stb_i;
  logic [31:0] iwb_dat_o;
  logic        iwb_ack_o;
  logic        iwb_err_o;
  logic [15:0] dwb_adr_i;
  logic [31:0] dwb_dat_i;
  logic        dwb_we_i;
  logic        dwb_stb_i;
  logic [31:0] dwb_dat_o;
  logic        dwb_ack_o;
  logic        dwb_err_o;
  logic [15:0] mwb_adr_o;
  logic [31:0] mwb_dat_o;
  logic        mwb_we_o;
  logic        mwb_stb_o;
  logic [31:0] mwb_dat_i;
  logic        mwb_ack_i;

  always #5 clk = ~clk;

  aemb_wb_arbiter #(.ISIZ(16), .DSIZ(16), .TOUT(TOUT)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (sys_rst_i),
    .iwb_adr_i (iwb_adr_i),
    .iwb_stb_i (iwb_stb_i),
    .iwb_dat_o (iwb_dat_o),
    .iwb_ack_o (iwb_ack_o),
    .iwb_err_o (iwb_err_o),
    .dwb_adr_i (dwb_adr_i),
    .dwb_dat_i (dwb_dat_i),
    .dwb_we_i  (dwb_we_i),
    .dwb_stb_i (dwb_stb_i),
    .dwb_dat_o (dwb_dat_o),
    .dwb_ack_o (dwb_ack_o),
    .dwb_err_o (dwb_err_o),
    .mwb_adr_o (mwb_adr_o),
    .mwb_dat_o (mwb_dat_o),
    .mwb_we_o  (mwb_we_o),
    .mwb_stb_o (mwb_stb_o),
    .mwb_dat_i (mwb_dat_i),
    .mwb_ack_i (mwb_ack_i)
  );

  // sel: which master's address should appear on mwb_adr_o (0 none, 1 i, 2 d)
  typedef struct {
    string      name;
    logic       rst, istb, dstb, dwe, mack;
    logic       e_stb;
    logic [1:0] sel;
    logic       e_we, e_iack, e_ierr, e_dack, e_derr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   iacks  = 0;
  int   dacks  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic rst, istb, dstb, dwe, mack,
                              input logic stb, input logic [1:0] sel,
                              input logic we, iack, ierr, dack, derr);
    vec_t v;
    v.name = n; v.rst = rst; v.istb = istb; v.dstb = dstb; v.dwe = dwe; v.mack = mack;
    v.e_stb = stb; v.sel = sel; v.e_we = we;
    v.e_iack = iack; v.e_ierr = ierr; v.e_dack = dack; v.e_derr = derr;
    return v;
  endfunction

  // Drive one cycle, queue its expectation, then sample at the falling edge.
  task automatic run_vec(input vec_t v);
    vec_t e;
    logic [15:0] exp_adr;
    logic [31:0] mdat;
    @(posedge clk);
    #1;
    mdat      = $urandom;
    sys_rst_i = v.rst;
    iwb_stb_i = v.istb;
    dwb_stb_i = v.dstb;
    dwb_we_i  = v.dwe;
    mwb_ack_i = v.mack;
    mwb_dat_i = mdat;
    sb.push_back(v);
    #4;
    e = sb.pop_front();
    exp_adr = (e.sel == 2'd1) ? IADR : (e.sel == 2'd2) ? DADR : 16'h0000;
    check({e.name, ".mwb_stb"}, 32'(mwb_stb_o), 32'(e.e_stb));
    check({e.name, ".mwb_adr"}, 32'(mwb_adr_o), 32'(exp_adr));
    check({e.name, ".mwb_we"},  32'(mwb_we_o),  32'(e.e_we));
    check({e.name, ".iwb_ack"}, 32'(iwb_ack_o), 32'(e.e_iack));
    check({e.name, ".iwb_err"}, 32'(iwb_err_o), 32'(e.e_ierr));
    check({e.name, ".dwb_ack"}, 32'(dwb_ack_o), 32'(e.e_dack));
    check({e.name, ".dwb_err"}, 32'(dwb_err_o), 32'(e.e_derr));
    check({e.name, ".mwb_dat"}, mwb_dat_o, DDAT);
    check({e.name, ".iwb_dat"}, iwb_dat_o, mdat);
    check({e.name, ".dwb_dat"}, dwb_dat_o, mdat);
    if (iwb_ack_o) iacks++;
    if (dwb_ack_o) dacks++;
  endtask

  initial begin
    //                 name     rst is ds we ak  stb sel we ia ie da de
    // reset with both strobes high, then iwb wins
    tbl.push_back(mk("rst0",   1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rst1",   1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rst2",   1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rel0",   0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rel1",   0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("iack",   0, 1, 1, 0, 1,  1, 1, 0, 1, 0, 0, 0));
    // single data write
    tbl.push_back(mk("wr_arb", 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("wr_gnt", 0, 0, 1, 1, 0,  1, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk("wr_ack", 0, 0, 1, 1, 1,  1, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk("wr_end", 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // abort in the first granted cycle, then a stray ack while idle
    tbl.push_back(mk("ab_arb", 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("ab_drop",0, 0, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk("stray",  0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("quiet",  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // iwb timeout (4th granted cycle) with dwb pending, then dwb granted
    tbl.push_back(mk("to_arb", 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("to_c0",  0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("to_c1",  0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("to_c2",  0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("to_err", 0, 1, 1, 0, 0,  1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk("to_dead",0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // dwb granted next; ack on its 4th cycle beats the timeout
    tbl.push_back(mk("da_c0",  0, 0, 1, 0, 0,  1, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk("da_c1",  0, 0, 1, 0, 0,  1, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk("da_c2",  0, 0, 1, 0, 0,  1, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk("da_c3",  0, 0, 1, 0, 1,  1, 2, 0, 0, 0, 1, 0));
    // same race for iwb
    tbl.push_back(mk("ia_arb", 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("ia_c0",  0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("ia_c1",  0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("ia_c2",  0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("ia_c3",  0, 1, 0, 0, 1,  1, 1, 0, 1, 0, 0, 0));
    // reset in the middle of a data grant with ack present
    tbl.push_back(mk("mr_arb", 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("mr_rst", 1, 1, 1, 1, 1,  1, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk("mr_idle",0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("mr_i",   0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("mr_drop",0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("mr_end", 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));

    sys_rst_i = 1'b1;
    iwb_adr_i = IADR;
    dwb_adr_i = DADR;
    dwb_dat_i = DDAT;
    iwb_stb_i = 1'b0;
    dwb_stb_i = 1'b0;
    dwb_we_i  = 1'b0;
    mwb_ack_i = 1'b0;
    mwb_dat_i = 32'h0;

    foreach (tbl[k]) run_vec(tbl[k]);

    // Round-robin: both strobes high, memory acks every strobed cycle.
    // Last grant above was iwb, so the pattern is idle, D, idle, I, ...
    iacks = 0;
    dacks = 0;
    for (int c = 0; c < 16; c++) begin
      logic is_gnt;
      logic is_d;
      is_gnt = (c % 2) == 1;
      is_d   = (c % 4) == 1;
      run_vec(mk($sformatf("rr%0d", c), 0, 1, 1, 0, is_gnt,
                 is_gnt, is_gnt ? (is_d ? 2'd2 : 2'd1) : 2'd0, 1'b0,
                 is_gnt && !is_d, 0, is_gnt && is_d, 0));
    end
    check("rr.iacks", 32'(iacks), 32'd4);
    check("rr.dacks", 32'(dacks), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
